// File: rtl/icache_refill_if.sv
// Refill engine bus bundle: miss side, memory burst read, data/tag RAM ports.
// slave is the refill engine view, master the surrounding environment.
interface icache_refill_if;
  logic        miss_req;
  logic [31:0] miss_addr;
  logic        busy;
  logic        refill_done;
  logic        rd_req;
  logic [31:0] rd_addr;
  logic        rd_rdy;
  logic        ret_valid;
  logic [31:0] ret_data;
  logic        data_en;
  logic [3:0]  data_wen;
  logic [9:0]  data_addr;
  logic [31:0] data_wdata;
  logic        tag_en;
  logic [3:0]  tag_wen;
  logic [6:0]  tag_addr;
  logic [20:0] tag_wdata;

  modport slave (
    input  miss_req, miss_addr, rd_rdy, ret_valid, ret_data,
    output busy, refill_done, rd_req, rd_addr,
    output data_en, data_wen, data_addr, data_wdata,
    output tag_en, tag_wen, tag_addr, tag_wdata
  );

  modport master (
    output miss_req, miss_addr, rd_rdy, ret_valid, ret_data,
    input  busy, refill_done, rd_req, rd_addr,
    input  data_en, data_wen, data_addr, data_wdata,
    input  tag_en, tag_wen, tag_addr, tag_wdata
  );
endinterface

// File: rtl/icache_refill.sv
// I-cache line refill engine: tag sweep after reset, then one burst
// read per miss written beat by beat into the data RAM, tag last.
module icache_refill #(
  parameter int LINE_WORDS = 8,
  parameter int SETS       = 128
) (
  input logic            clk,
  input logic            rst,
  icache_refill_if.slave bus
);

  typedef enum logic [2:0] {
    INIT, IDLE, REQ, RECV, DONE
  } state_e;

  state_e      state_q, state_d;
  logic [6:0]  sweep_q, sweep_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [26:0] addr_q, addr_d;

  logic unused_lo;
  assign unused_lo = ^bus.miss_addr[4:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= INIT;
      sweep_q <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
    end
  end

  assign bus.busy = (state_q != IDLE);

  always_comb begin
    state_d         = state_q;
    sweep_d         = sweep_q;
    cnt_d           = cnt_q;
    addr_d          = addr_q;
    bus.rd_req      = 1'b0;
    bus.rd_addr     = {addr_q, 5'b0};
    bus.refill_done = 1'b0;
    bus.data_en     = 1'b0;
    bus.data_wen    = 4'h0;
    bus.data_addr   = {addr_q[6:0], cnt_q};
    bus.data_wdata  = bus.ret_data;
    bus.tag_en      = 1'b0;
    bus.tag_wen     = 4'h0;
    bus.tag_addr    = addr_q[6:0];
    bus.tag_wdata   = '0;
    unique case (state_q)
      INIT: begin
        bus.tag_en   = 1'b1;
        bus.tag_wen  = 4'hF;
        bus.tag_addr = sweep_q;
        sweep_d      = sweep_q + 7'd1;
        if (sweep_q == 7'(SETS - 1)) begin
          sweep_d = '0;
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (bus.miss_req) begin
          // Victim tag is invalidated before any of its data is overwritten.
          addr_d       = bus.miss_addr[31:5];
          bus.tag_en   = 1'b1;
          bus.tag_wen  = 4'hF;
          bus.tag_addr = bus.miss_addr[11:5];
          state_d      = REQ;
        end
      end
      REQ: begin
        bus.rd_req = 1'b1;
        if (bus.rd_rdy) begin
          cnt_d   = '0;
          state_d = RECV;
        end
      end
      RECV: begin
        if (bus.ret_valid) begin
          bus.data_en  = 1'b1;
          bus.data_wen = 4'hF;
          cnt_d        = cnt_q + 3'd1;
          if (cnt_q == 3'(LINE_WORDS - 1)) begin
            bus.tag_en    = 1'b1;
            bus.tag_wen   = 4'hF;
            bus.tag_wdata = {1'b1, addr_q[26:7]};
            cnt_d         = '0;
            state_d       = DONE;
          end
        end
      end
      DONE: begin
        bus.refill_done = 1'b1;
        state_d         = IDLE;
      end
      default: state_d = INIT;
    endcase
  end

endmodule

// File: tb/tb_icache_refill.sv
// Directed bench for icache_refill: sweep, refills with gaps and
// stalls, ignored beats, and reset in the middle of a burst.
module tb_icache_refill;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  icache_refill_if bif();

  icache_refill #(
    .LINE_WORDS(8),
    .SETS(128)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sweep(input logic miss_on);
    for (int i = 0; i < 128; i++) begin
      bif.ret_valid = i[0];
      bif.ret_data  = 32'hBAD0_0000 + i;
      bif.rd_rdy    = 1'b1;
      @(negedge clk);
      chk("sweep_tag_en", bif.tag_en, 1);
      chk("sweep_tag_wen", bif.tag_wen, 4'hF);
      chk("sweep_tag_addr", bif.tag_addr, i);
      chk("sweep_tag_wdata", bif.tag_wdata, 0);
      chk("sweep_data_en", bif.data_en, 0);
      chk("sweep_busy", bif.busy, 1);
      chk("sweep_rd_req", bif.rd_req, 0);
      if (miss_on) chk("sweep_miss_wait", bif.rd_req, 0);
      next_cycle();
    end
    bif.ret_valid = 1'b0;
    bif.rd_rdy    = 1'b0;
  endtask

  task automatic refill(input logic [31:0] a, input logic [6:0] set,
                        input logic [20:0] tag, input int delay,
                        input int gap, input int nbeats,
                        input logic [31:0] seed);
    logic [31:0] d;
    logic [2:0]  b3;
    bif.miss_req  = 1'b1;
    bif.miss_addr = a;
    bif.rd_rdy    = 1'b0;
    bif.ret_valid = 1'b0;
    @(negedge clk);
    chk("idle_busy", bif.busy, 0);
    chk("inval_tag_en", bif.tag_en, 1);
    chk("inval_tag_wen", bif.tag_wen, 4'hF);
    chk("inval_tag_addr", bif.tag_addr, set);
    chk("inval_tag_wdata", bif.tag_wdata, 0);
    chk("idle_rd_req", bif.rd_req, 0);
    next_cycle();
    for (int k = 0; k <= delay; k++) begin
      bif.rd_rdy = (k == delay);
      @(negedge clk);
      chk("req_rd_req", bif.rd_req, 1);
      chk("req_rd_addr", bif.rd_addr, {a[31:5], 5'b0});
      chk("req_data_en", bif.data_en, 0);
      chk("req_tag_en", bif.tag_en, 0);
      chk("req_busy", bif.busy, 1);
      next_cycle();
    end
    bif.rd_rdy = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      for (int g = 0; g < gap; g++) begin
        bif.ret_valid = 1'b0;
        bif.ret_data  = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("gap_data_en", bif.data_en, 0);
        chk("gap_tag_en", bif.tag_en, 0);
        chk("gap_rd_req", bif.rd_req, 0);
        next_cycle();
      end
      d  = seed + 32'h0101_0101 * b;
      b3 = b[2:0];
      bif.ret_valid = 1'b1;
      bif.ret_data  = d;
      @(negedge clk);
      chk("beat_data_en", bif.data_en, 1);
      chk("beat_data_wen", bif.data_wen, 4'hF);
      chk("beat_data_addr", bif.data_addr, {set, b3});
      chk("beat_data_wdata", bif.data_wdata, d);
      chk("beat_tag_en", bif.tag_en, b == 7);
      if (b == 7) begin
        chk("valid_tag_wen", bif.tag_wen, 4'hF);
        chk("valid_tag_addr", bif.tag_addr, set);
        chk("valid_tag_wdata", bif.tag_wdata, tag);
      end
      chk("beat_done", bif.refill_done, 0);
      next_cycle();
    end
    bif.ret_valid = 1'b0;
    if (nbeats == 8) begin
      @(negedge clk);
      chk("done_pulse", bif.refill_done, 1);
      chk("done_busy", bif.busy, 1);
      chk("done_data_en", bif.data_en, 0);
      chk("done_tag_en", bif.tag_en, 0);
      next_cycle();
      bif.miss_req = 1'b0;
      @(negedge clk);
      chk("after_done", bif.refill_done, 0);
      chk("after_busy", bif.busy, 0);
      chk("after_tag_en", bif.tag_en, 0);
      next_cycle();
    end
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    rst           = 1'b1;
    bif.miss_req  = 1'b0;
    bif.miss_addr = '0;
    bif.rd_rdy    = 1'b0;
    bif.ret_valid = 1'b0;
    bif.ret_data  = '0;

    @(negedge clk);
    chk("rst_rd_req", bif.rd_req, 0);
    chk("rst_done", bif.refill_done, 0);
    chk("rst_data_en", bif.data_en, 0);
    chk("rst_data_wen", bif.data_wen, 0);
    chk("rst_busy", bif.busy, 1);
    next_cycle();
    rst = 1'b0;

    sweep(1'b0);

    bif.ret_valid = 1'b1;
    bif.ret_data  = 32'h1234_5678;
    @(negedge clk);
    chk("idle_busy", bif.busy, 0);
    chk("idle_ret_data_en", bif.data_en, 0);
    chk("idle_ret_tag_en", bif.tag_en, 0);
    chk("idle_ret_rd_req", bif.rd_req, 0);
    next_cycle();
    bif.ret_valid = 1'b0;

    refill(32'h1FC0_0A44, 7'h52, 21'h11FC00, 0, 0, 8, 32'hD000_0000);
    refill(32'h1FC0_0A44, 7'h52, 21'h11FC00, 0, 3, 8, 32'hA000_0000);
    refill(32'hABCD_E010, 7'h00, 21'h1ABCDE, 5, 0, 8, 32'h5000_0007);

    refill(32'h0000_3FE8, 7'h7F, 21'h100003, 0, 0, 5, 32'h7700_0000);
    rst           = 1'b1;
    bif.ret_valid = 1'b1;
    bif.ret_data  = 32'hCAFE_0005;
    #1;
    chk("mid_rst_data_en", bif.data_en, 0);
    chk("mid_rst_tag_addr", bif.tag_addr, 0);
    chk("mid_rst_tag_wdata", bif.tag_wdata, 0);
    chk("mid_rst_rd_req", bif.rd_req, 0);
    chk("mid_rst_busy", bif.busy, 1);
    next_cycle();
    @(negedge clk);
    chk("rst_hold_data_en", bif.data_en, 0);
    chk("rst_hold_tag_wdata", bif.tag_wdata, 0);
    next_cycle();
    rst           = 1'b0;
    bif.miss_req  = 1'b1;
    bif.miss_addr = 32'h0000_3FE8;

    sweep(1'b1);

    refill(32'h0000_3FE8, 7'h7F, 21'h100003, 1, 1, 8, 32'h7700_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
